// File: rtl/cdc_4phase_src_rr_arb.sv
// Round-robin front end sharing one 4-phase bundled-data CDC link among NUM_REQ
// valid/ready requesters; the winner's payload is sent tagged with its index.
module cdc_4phase_src_rr_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 2,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic                          async_req_o,
  input  logic                          async_ack_i,
  output logic [IDX_W+DATA_WIDTH-1:0]   async_data_o,
  output logic                          busy_o,
  output logic [IDX_W-1:0]              grant_idx_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETUP       = 2'd1,
    WAIT_ACK_HI = 2'd2,
    WAIT_ACK_LO = 2'd3
  } state_t;

  state_t                        state_reg, state_next;
  logic                          req_reg, req_next;
  logic [IDX_W+DATA_WIDTH-1:0]   data_reg, data_next;
  logic [IDX_W-1:0]              grant_reg, grant_next;
  logic [IDX_W-1:0]              ptr_reg, ptr_next;
  logic [SYNC_STAGES-1:0]        ack_sync_reg;
  logic                          ack_s;

  logic [DATA_WIDTH-1:0]         payload [NUM_REQ];
  logic                          found;
  logic [IDX_W-1:0]              win_idx;
  logic [IDX_W-1:0]              cand_idx;
  int unsigned                   cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign payload[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // The ack is asynchronous to clk_i; only the last stage is ever observed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], async_ack_i};
    end
  end

  assign ack_s = ack_sync_reg[SYNC_STAGES-1];

  // Scan ptr, ptr+1, ... wrapping; the first valid requester wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_valid_i[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state_reg == IDLE && found) req_ready_o[win_idx] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    data_next  = data_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          data_next  = {win_idx, payload[win_idx]};
          grant_next = win_idx;
          ptr_next   = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        // Data has been stable for a full cycle before req rises.
        req_next   = 1'b1;
        state_next = WAIT_ACK_HI;
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          req_next   = 1'b0;
          state_next = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) state_next = IDLE;
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      data_reg  <= '0;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      data_reg  <= data_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign async_req_o  = req_reg;
  assign async_data_o = data_reg;
  assign grant_idx_o  = grant_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_cdc_4phase_src_rr_arb.sv
// Directed and randomized bench for the round-robin 4-phase CDC source, with an
// in-bench destination ack model and a round-robin reference model.
module tb_cdc_4phase_src_rr_arb;
  localparam int NUM_REQ = 4;
  localparam int DW      = 2;
  localparam int SS      = 2;
  localparam int IW      = 2;
  localparam int AW      = IW + DW;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                 async_req;
  logic                 async_ack;
  logic [AW-1:0]        async_data;
  logic                 busy;
  logic [IW-1:0]        grant_idx;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: round-robin pointer and the last accepted word.
  int            m_ptr;
  logic [AW-1:0] m_data;
  logic [IW-1:0] m_grant;

  cdc_4phase_src_rr_arb #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .SYNC_STAGES(SS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .async_req_o(async_req), .async_ack_i(async_ack), .async_data_o(async_data),
    .busy_o(busy), .grant_idx_o(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (ptr + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock; outputs sampled on the falling edge, invariants checked every cycle.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("data_stable", async_data, m_data);
    chk("grant_idx", grant_idx, m_grant);
    chk("ready_onehot0", $onehot0(req_ready), 1);
    if (busy) chk("ready_idle_only", req_ready, 0);
  endtask

  task automatic scramble(input int g);
    for (int i = 0; i < NUM_REQ; i++)
      if (i != g && $urandom_range(1) == 1) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    async_ack = 1'b0;
    m_ptr     = 0;
    m_data    = '0;
    m_grant   = '0;
    #1;
    chk("rst_req", async_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", async_data, 0);
    chk("rst_grant", grant_idx, 0);
    repeat (2) @(negedge clk);
    chk("rst_ready_held", req_ready, 0);
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic do_xfer(input bit keep_valid, input int dly_hi, input int dly_lo,
                         input bit scr, output int g);
    #1;
    g = rr_pick(req_valid, m_ptr);
    if (g < 0) begin
      chk("xfer_has_valid", 0, 1);
      return;
    end
    chk("ready_grant", req_ready, 32'd1 << g);
    m_data  = {IW'(g), req_data[g*DW +: DW]};
    m_grant = IW'(g);
    m_ptr   = (g == NUM_REQ-1) ? 0 : g + 1;
    cyc();
    if (!keep_valid) req_valid[g] = 1'b0;
    chk("setup_req_low", async_req, 0);
    chk("setup_busy", busy, 1);
    if (scr) scramble(g);
    cyc();
    chk("req_rise", async_req, 1);
    repeat (dly_hi) begin
      if (scr) scramble(g);
      cyc();
      chk("req_hold", async_req, 1);
    end
    async_ack = 1'b1;
    repeat (SS) begin
      cyc();
      chk("req_before_ack_sync", async_req, 1);
    end
    cyc();
    chk("req_fall", async_req, 0);
    repeat (dly_lo) begin
      if (scr) scramble(g);
      cyc();
      chk("req_low_ack_hi", async_req, 0);
      chk("busy_ack_hi", busy, 1);
    end
    async_ack = 1'b0;
    repeat (SS) begin
      cyc();
      chk("busy_before_ack_lo_sync", busy, 1);
    end
    cyc();
    chk("busy_clear", busy, 0);
    chk("req_idle", async_req, 0);
    $display("xfer: grant=%0d async_data=%h", g, m_data);
  endtask

  initial begin
    int g;
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    // Reset state, with every requester valid to show ready is gated by reset.
    req_valid = '1;
    req_data  = 8'hE4;
    do_reset();
    req_valid = '0;
    cyc();

    // Single transfer from requester 2 carrying 2'b11.
    req_valid = 4'b0100;
    req_data[5:4] = 2'b11;
    do_xfer(1'b0, 2, 1, 1'b0, g);
    chk("single_data", async_data, 4'b1011);
    chk("single_grant", grant_idx, 2);

    // Round-robin with all four valid and payload i on requester i.
    @(negedge clk);
    do_reset();
    req_valid = 4'b1111;
    req_data  = 8'b11_10_01_00;
    for (int k = 0; k < 6; k++) begin
      do_xfer(1'b1, k % 3, 1, 1'b0, g);
      chk("rr_order", grant_idx, rr_exp[k]);
      chk("rr_payload", async_data, {rr_exp[k][1:0], rr_exp[k][1:0]});
    end

    // Pointer is 2 after granting 1: with only 0 and 3 valid, 3 goes first.
    req_valid = 4'b1001;
    do_xfer(1'b0, 1, 0, 1'b0, g);
    chk("skip_first", grant_idx, 3);
    do_xfer(1'b0, 0, 2, 1'b0, g);
    chk("skip_second", grant_idx, 0);

    // Spurious ack in IDLE with nothing valid.
    req_valid = '0;
    async_ack = 1'b1;
    repeat (4) begin
      cyc();
      chk("spur_busy", busy, 0);
      chk("spur_req", async_req, 0);
    end
    async_ack = 1'b0;
    repeat (SS + 1) begin
      cyc();
      chk("spur_after_busy", busy, 0);
    end

    // Random requesters, ack delays and payload churn on non-granted ports.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i]) req_data[i*DW +: DW] = DW'($urandom);
      req_valid = req_valid | NUM_REQ'($urandom);
      if (req_valid == '0) req_valid = NUM_REQ'(1 << $urandom_range(NUM_REQ-1));
      do_xfer(1'b0, $urandom_range(0, 6), $urandom_range(0, 6), 1'b1, g);
    end

    // Reset during WAIT_ACK_HI.
    req_valid = 4'b0010;
    #1;
    g = rr_pick(req_valid, m_ptr);
    chk("mid_ready", req_ready, 32'd1 << g);
    m_data  = {IW'(g), req_data[g*DW +: DW]};
    m_grant = IW'(g);
    m_ptr   = (g == NUM_REQ-1) ? 0 : g + 1;
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    chk("mid_req_high", async_req, 1);
    chk("mid_busy", busy, 1);
    req_valid = 4'b1111;
    do_reset();
    do_xfer(1'b0, 1, 1, 1'b0, g);
    chk("post_reset_grant", grant_idx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
